// File: rtl/seq_pipe_pkg.sv
// Shared types for the seq_pipe skid buffer.
// State encoding doubles as the occupancy count.
package seq_pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } skid_state_e;

  localparam logic [63:0] RST_DATA = 64'd0;

endpackage

// File: rtl/seq_pipe_reg_en.sv
// Enabled data register, async active-high reset.
// Holds one skid buffer entry.
module seq_pipe_reg_en
  import seq_pipe_pkg::*;
#(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [nbits-1:0] d,
  output logic [nbits-1:0] q
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q <= RST_DATA[nbits-1:0];
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/seq_pipe_skid_buffer_2entry.sv
// Two-entry elastic skid buffer, FIFO order.
// Handshake outputs come only from registered state.
module seq_pipe_skid_buffer_2entry
  import seq_pipe_pkg::*;
#(
  parameter int nbits = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [nbits-1:0] in_,
  input  logic             in_val,
  output logic             in_rdy,
  output logic [nbits-1:0] out,
  output logic             out_val,
  input  logic             out_rdy,
  output logic [1:0]       count
);

  skid_state_e      state;
  skid_state_e      state_nxt;
  logic             in_fire;
  logic             out_fire;
  logic             main_en;
  logic             skid_en;
  logic [nbits-1:0] main_d;
  logic [nbits-1:0] main_q;
  logic [nbits-1:0] skid_q;

  assign in_rdy   = (state != TWO) & ~reset;
  assign out_val  = (state != EMPTY);
  assign out      = main_q;
  assign count    = state;
  assign in_fire  = in_val & in_rdy;
  assign out_fire = out_val & out_rdy;

  // Head refills from skid only when draining out of TWO
  assign main_d = (state == TWO) ? skid_q : in_;

  always_comb begin
    state_nxt = state;
    main_en   = 1'b0;
    skid_en   = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          main_en   = 1'b1;
          state_nxt = ONE;
        end
      end
      ONE: begin
        case ({in_fire, out_fire})
          2'b11: main_en = 1'b1;
          2'b10: begin
            skid_en   = 1'b1;
            state_nxt = TWO;
          end
          2'b01: state_nxt = EMPTY;
          default: state_nxt = ONE;
        endcase
      end
      TWO: begin
        if (out_fire) begin
          main_en   = 1'b1;
          state_nxt = ONE;
        end
      end
      default: state_nxt = EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  seq_pipe_reg_en #(.nbits(nbits)) u_main (
    .clk   (clk),
    .reset (reset),
    .en    (main_en),
    .d     (main_d),
    .q     (main_q)
  );

  seq_pipe_reg_en #(.nbits(nbits)) u_skid (
    .clk   (clk),
    .reset (reset),
    .en    (skid_en),
    .d     (in_),
    .q     (skid_q)
  );

endmodule

// File: tb/tb_seq_pipe_skid_buffer_2entry.sv
// Scoreboard bench for the 2-entry skid buffer.
// A queue model tracks occupancy and the head value.
module tb_seq_pipe_skid_buffer_2entry;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] in_;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] out;
  logic       out_val;
  logic       out_rdy;
  logic [1:0] count;

  logic [7:0] q[$];
  logic [7:0] mlast;
  int         checks;
  int         passes;

  seq_pipe_skid_buffer_2entry #(.nbits(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .in_     (in_),
    .in_val  (in_val),
    .in_rdy  (in_rdy),
    .out     (out),
    .out_val (out_val),
    .out_rdy (out_rdy),
    .count   (count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d", passes, checks);
    $fatal(1, "timeout");
  end

  // Advance one edge and update the model from the pre-edge handshake
  task automatic tick();
    bit inf;
    bit outf;
    logic [7:0] din;
    inf  = in_val && !reset && (q.size() < 2);
    outf = (q.size() > 0) && out_rdy;
    din  = in_;
    @(posedge clk);
    #1;
    if (outf) void'(q.pop_front());
    if (inf) q.push_back(din);
    if (q.size() > 0) mlast = q[0];
  endtask

  task automatic test_reset();
    reset   = 1'b1;
    in_val  = 1'b0;
    in_     = 8'h00;
    out_rdy = 1'b1;
    q.delete();
    mlast = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_val, count, in_rdy, out} !== 12'h000)
      $display("FAIL reset_hold: got val=%b cnt=%0d rdy=%b out=%h want 0,0,0,00",
               out_val, count, in_rdy, out);
    else passes++;
    reset = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1) $display("FAIL reset_release_rdy: got %b want 1", in_rdy);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (out_val !== 1'b0 || count !== 2'd0 || in_rdy !== 1'b1 || out !== 8'h00)
        $display("FAIL idle[%0d]: got val=%b cnt=%0d rdy=%b out=%h want 0,0,1,00",
                 i, out_val, count, in_rdy, out);
      else passes++;
    end
  endtask

  task automatic test_stream();
    logic [7:0] seq [4];
    seq = '{8'h0a, 8'h0b, 8'h0c, 8'h0d};
    out_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_val = 1'b1;
      in_    = seq[i];
      checks++;
      if (in_rdy !== 1'b1) $display("FAIL stream_rdy[%0d]: got %b want 1", i, in_rdy);
      else passes++;
      tick();
      checks++;
      if (out !== q[0] || out !== seq[i] || out_val !== 1'b1 || count !== 2'd1)
        $display("FAIL stream[%0d]: got out=%h val=%b cnt=%0d want %h,1,1",
                 i, out, out_val, count, seq[i]);
      else passes++;
    end
    in_val = 1'b0;
    tick();
    checks++;
    if (count !== 2'd0 || out_val !== 1'b0)
      $display("FAIL stream_drain: got cnt=%0d val=%b want 0,0", count, out_val);
    else passes++;
  endtask

  task automatic test_backpressure();
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_     = 8'h11;
    tick();
    checks++;
    if (count !== 2'd1 || out !== 8'h11)
      $display("FAIL bp_fill1: got cnt=%0d out=%h want 1,11", count, out);
    else passes++;
    in_ = 8'h22;
    tick();
    checks++;
    if (count !== 2'd2 || in_rdy !== 1'b0 || out !== 8'h11)
      $display("FAIL bp_fill2: got cnt=%0d rdy=%b out=%h want 2,0,11", count, in_rdy, out);
    else passes++;
    in_ = 8'h33;
    tick();
    checks++;
    if (count !== 2'd2 || out !== 8'h11 || q.size() != 2)
      $display("FAIL bp_reject: got cnt=%0d out=%h want 2,11", count, out);
    else passes++;
    out_rdy = 1'b1;
    checks++;
    if (out !== 8'h11 || in_rdy !== 1'b0)
      $display("FAIL bp_pop11: got out=%h rdy=%b want 11,0", out, in_rdy);
    else passes++;
    tick();
    checks++;
    if (out !== 8'h22 || in_rdy !== 1'b1 || count !== 2'd1)
      $display("FAIL bp_pop22: got out=%h rdy=%b cnt=%0d want 22,1,1", out, in_rdy, count);
    else passes++;
    tick();
    in_val = 1'b0;
    checks++;
    if (out !== 8'h33 || count !== 2'd1 || q[0] !== 8'h33)
      $display("FAIL bp_pop33: got out=%h cnt=%0d want 33,1", out, count);
    else passes++;
    tick();
    checks++;
    if (count !== 2'd0 || out_val !== 1'b0 || out !== 8'h33)
      $display("FAIL bp_empty: got cnt=%0d val=%b out=%h want 0,0,33", count, out_val, out);
    else passes++;
  endtask

  task automatic test_simul();
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_     = 8'h44;
    tick();
    checks++;
    if (out !== 8'h44 || count !== 2'd1)
      $display("FAIL simul_load: got out=%h cnt=%0d want 44,1", out, count);
    else passes++;
    in_     = 8'h55;
    out_rdy = 1'b1;
    tick();
    checks++;
    if (out !== 8'h55 || count !== 2'd1 || out_val !== 1'b1)
      $display("FAIL simul_swap: got out=%h cnt=%0d val=%b want 55,1,1", out, count, out_val);
    else passes++;
    in_val = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    out_rdy = 1'b0;
    in_val  = 1'b1;
    in_     = 8'h66;
    tick();
    in_ = 8'h77;
    tick();
    in_val = 1'b0;
    checks++;
    if (count !== 2'd2 || out !== 8'h66)
      $display("FAIL mid_fill: got cnt=%0d out=%h want 2,66", count, out);
    else passes++;
    #3;
    reset = 1'b1;
    #1;
    checks++;
    if (out_val !== 1'b0 || count !== 2'd0 || out !== 8'h00 || in_rdy !== 1'b0)
      $display("FAIL mid_reset: got val=%b cnt=%0d out=%h rdy=%b want 0,0,00,0",
               out_val, count, out, in_rdy);
    else passes++;
    q.delete();
    mlast = 8'h00;
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (in_rdy !== 1'b1) $display("FAIL mid_release_rdy: got %b want 1", in_rdy);
    else passes++;
    in_val  = 1'b1;
    in_     = 8'h88;
    out_rdy = 1'b1;
    tick();
    in_val = 1'b0;
    checks++;
    if (out !== 8'h88 || out_val !== 1'b1 || count !== 2'd1)
      $display("FAIL mid_push88: got out=%h val=%b cnt=%0d want 88,1,1", out, out_val, count);
    else passes++;
    tick();
    checks++;
    if (count !== 2'd0 || out_val !== 1'b0)
      $display("FAIL mid_drain: got cnt=%0d val=%b want 0,0", count, out_val);
    else passes++;
  endtask

  task automatic test_random();
    logic [7:0] exp_out;
    in_val = 1'b0;
    for (int i = 0; i < 200; i++) begin
      // An unaccepted offer is held until it goes through
      if (!(in_val && q.size() == 2)) begin
        in_val = 1'($urandom_range(0, 1));
        in_    = 8'($urandom);
      end
      out_rdy = 1'($urandom_range(0, 1));
      exp_out = (q.size() > 0) ? q[0] : mlast;
      checks++;
      if (count !== 2'(q.size()) || out_val !== (q.size() > 0) ||
          in_rdy !== (q.size() < 2) || out !== exp_out || count > 2'd2)
        $display("FAIL rand[%0d]: got cnt=%0d val=%b rdy=%b out=%h want %0d,%b,%b,%h",
                 i, count, out_val, in_rdy, out, q.size(), q.size() > 0,
                 q.size() < 2, exp_out);
      else passes++;
      tick();
    end
    in_val = 1'b0;
  endtask

  initial begin
    checks = 0;
    passes = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_simul();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
